// File: rtl/tft_touch_reader_pkg.sv
// tft_touch_reader_pkg: shared state encoding and frame constants for the touch reader
package tft_touch_reader_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_X,
    ST_FRAME_X,
    ST_GAP,
    ST_CS_Y,
    ST_FRAME_Y,
    ST_SETTLE,
    ST_CHECK
  } state_t;
  localparam int FRAME_BITS = 24;
  localparam int CMD_BITS = 8;
  localparam int RESULT_W = 12;
  localparam logic [7:0] DEF_CMD_X = 8'hD1;
  localparam logic [7:0] DEF_CMD_Y = 8'h90;
endpackage

// File: rtl/tft_touch_reader_spi_frame.sv
// tft_touch_reader_spi_frame: one 24-bit DCLK exchange, command out MSB-first, 12-bit result in
module tft_touch_reader_spi_frame
  import tft_touch_reader_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          cmd,
  input  logic                sdo,
  output logic                sclk,
  output logic                sdi,
  output logic                done,
  output logic [RESULT_W-1:0] result
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'(FRAME_BITS - 1);
  localparam logic [4:0] DATA_FIRST = 5'(CMD_BITS + 1);
  localparam logic [4:0] DATA_LAST = 5'(CMD_BITS + RESULT_W);
  logic                active;
  logic                high;
  logic [DW-1:0]       div;
  logic [4:0]          k;
  logic [6:0]          cmd_sh;
  logic [RESULT_W-1:0] cap;
  logic                div_end;
  logic                data_bit;
  // phase-end and result-window decodes; bit 8 is the converter's busy slot and bits 21..23 are trailing zeros
  always_comb begin
    div_end = div == DIV_LAST;
    data_bit = (k >= DATA_FIRST) && (k <= DATA_LAST);
  end
  // bit sequencer: low phase then high phase per bit, DIN moves at low-phase start, DOUT sampled at high-phase end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      high <= 1'b0;
      div <= '0;
      k <= '0;
      cmd_sh <= '0;
      cap <= '0;
      sclk <= 1'b0;
      sdi <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active <= 1'b1;
          high <= 1'b0;
          div <= '0;
          k <= '0;
          cmd_sh <= cmd[6:0];
          sdi <= cmd[7];
          cap <= '0;
        end
      end else if (!div_end) begin
        div <= div + 1'b1;
      end else begin
        div <= '0;
        if (!high) begin
          high <= 1'b1;
          sclk <= 1'b1;
        end else begin
          high <= 1'b0;
          sclk <= 1'b0;
          if (data_bit) cap <= {cap[RESULT_W-2:0], sdo};
          if (k == BIT_LAST) begin
            active <= 1'b0;
            done <= 1'b1;
            result <= cap;
          end else begin
            k <= k + 1'b1;
            cmd_sh <= {cmd_sh[5:0], 1'b0};
            sdi <= cmd_sh[6];
          end
        end
      end
    end
  end
endmodule

// File: rtl/tft_touch_reader.sv
// tft_touch_reader: debounced pen detect and periodic X/Y sampling of an XPT2046-class touch controller
module tft_touch_reader
  import tft_touch_reader_pkg::*;
#(
  parameter int         CLK_DIV       = 25,
  parameter int         SAMPLE_PERIOD = 500000,
  parameter int         PEN_DEBOUNCE  = 50000,
  parameter logic [7:0] CMD_X         = DEF_CMD_X,
  parameter logic [7:0] CMD_Y         = DEF_CMD_Y
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                t_irq_n,
  input  logic                t_do,
  output logic                t_clk,
  output logic                t_cs_n,
  output logic                t_din,
  output logic [RESULT_W-1:0] sample_x,
  output logic [RESULT_W-1:0] sample_y,
  output logic                sample_valid,
  output logic                pen_down,
  output logic                busy
);
  localparam int CW = $clog2(4 * CLK_DIV + 1);
  localparam int TW = $clog2(SAMPLE_PERIOD + 1);
  localparam int BW = $clog2(PEN_DEBOUNCE + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(4 * CLK_DIV - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [BW-1:0] DEB_LAST = BW'(PEN_DEBOUNCE - 1);
  state_t              st;
  logic                irq_meta;
  logic                irq_s;
  logic                do_meta;
  logic                do_s;
  logic [BW-1:0]       deb_cnt;
  logic [TW-1:0]       tmr;
  logic [CW-1:0]       cnt;
  logic                frame_start;
  logic                frame_done;
  logic [7:0]          frame_cmd;
  logic [RESULT_W-1:0] frame_result;
  logic [RESULT_W-1:0] x_res;
  logic [RESULT_W-1:0] y_res;
  logic                wrap;
  logic                cnt_end;
  logic                settle_end;
  // terminal-count decodes and command selection for the frame engine
  always_comb begin
    wrap = tmr == TMR_LAST;
    cnt_end = cnt == DIV_LAST;
    settle_end = cnt == SETTLE_LAST;
    frame_cmd = (st == ST_FRAME_Y) ? CMD_Y : CMD_X;
  end
  // two-flop synchronizers for the asynchronous controller outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_meta <= 1'b1;
      irq_s <= 1'b1;
      do_meta <= 1'b0;
      do_s <= 1'b0;
    end else begin
      irq_meta <= t_irq_n;
      irq_s <= irq_meta;
      do_meta <= t_do;
      do_s <= do_meta;
    end
  end
  // pen debounce, frozen during a pair because PENIRQ is meaningless while converting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      pen_down <= 1'b0;
    end else if (!busy) begin
      if (irq_s == pen_down) begin
        deb_cnt <= (deb_cnt == DEB_LAST) ? '0 : deb_cnt + 1'b1;
        if (deb_cnt == DEB_LAST) pen_down <= ~pen_down;
      end else begin
        deb_cnt <= '0;
      end
    end
  end
  // free-running sample period timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmr <= '0;
    else tmr <= wrap ? '0 : tmr + 1'b1;
  end
  // pair sequencer: X frame, CS gap, Y frame (re-arms PENIRQ), settle, then validate against PENIRQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= ST_IDLE;
      cnt <= '0;
      t_cs_n <= 1'b1;
      busy <= 1'b0;
      frame_start <= 1'b0;
      x_res <= '0;
      y_res <= '0;
      sample_x <= '0;
      sample_y <= '0;
      sample_valid <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      sample_valid <= 1'b0;
      case (st)
        ST_IDLE: if (wrap && enable && pen_down) begin
          st <= ST_CS_X;
          t_cs_n <= 1'b0;
          busy <= 1'b1;
          cnt <= '0;
        end
        ST_CS_X, ST_CS_Y: if (cnt_end) begin
          st <= (st == ST_CS_X) ? ST_FRAME_X : ST_FRAME_Y;
          frame_start <= 1'b1;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        ST_FRAME_X: if (frame_done) begin
          x_res <= frame_result;
          st <= ST_GAP;
          t_cs_n <= 1'b1;
        end
        ST_GAP: if (cnt_end) begin
          st <= ST_CS_Y;
          t_cs_n <= 1'b0;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        ST_FRAME_Y: if (frame_done) begin
          y_res <= frame_result;
          st <= ST_SETTLE;
          t_cs_n <= 1'b1;
        end
        ST_SETTLE: if (settle_end) begin
          st <= ST_CHECK;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        ST_CHECK: begin
          if (!irq_s) begin
            sample_x <= x_res;
            sample_y <= y_res;
            sample_valid <= 1'b1;
          end
          st <= ST_IDLE;
          busy <= 1'b0;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end
  tft_touch_reader_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
    .clk(clk),
    .rst(rst),
    .start(frame_start),
    .cmd(frame_cmd),
    .sdo(do_s),
    .sclk(t_clk),
    .sdi(t_din),
    .done(frame_done),
    .result(frame_result)
  );
endmodule

// File: tb/tb_tft_touch_reader.sv
// tb_tft_touch_reader: directed/random checks of the touch reader against a behavioural XPT2046 model
module tb_tft_touch_reader;
  localparam int CLK_DIV = 2;
  localparam int SAMPLE_PERIOD = 200;
  localparam int PEN_DEBOUNCE = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic t_irq_n = 1'b1;
  logic t_do = 1'b0;
  logic t_clk, t_cs_n, t_din, sample_valid, pen_down, busy;
  logic [11:0] sample_x, sample_y;
  int checks = 0;
  int failures = 0;
  tft_touch_reader #(
    .CLK_DIV(CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .PEN_DEBOUNCE(PEN_DEBOUNCE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .t_irq_n(t_irq_n),
    .t_do(t_do),
    .t_clk(t_clk),
    .t_cs_n(t_cs_n),
    .t_din(t_din),
    .sample_x(sample_x),
    .sample_y(sample_y),
    .sample_valid(sample_valid),
    .pen_down(pen_down),
    .busy(busy)
  );
  always #5 clk = ~clk;
  // touch controller model: latches the control byte on DCLK rises, shifts the conversion out on DCLK falls
  logic [11:0] mx = '0;
  logic [11:0] my = '0;
  logic [7:0] m_cmd = '0;
  int m_edges = 0;
  logic prev_clk = 1'b0;
  logic prev_cs = 1'b1;
  int cs_falls = 0;
  int clk_rises = 0;
  int strobes = 0;
  int pen_rises = 0;
  logic [7:0] cmd_q[$];
  int edge_q[$];
  function automatic logic dout_bit(int k, logic [7:0] c, logic [11:0] x, logic [11:0] y);
    logic [11:0] d;
    d = (c == 8'hD1) ? x : y;
    return (k >= 9 && k <= 20) ? d[20-k] : 1'b0;
  endfunction
  always @(t_clk or t_cs_n) begin
    if (prev_cs === 1'b1 && t_cs_n === 1'b0) begin
      m_edges = 0;
      m_cmd = '0;
      t_do = 1'b0;
      cs_falls++;
    end else if (prev_cs === 1'b0 && t_cs_n === 1'b1) begin
      cmd_q.push_back(m_cmd);
      edge_q.push_back(m_edges);
    end
    if (prev_clk === 1'b0 && t_clk === 1'b1) begin
      clk_rises++;
      if (t_cs_n === 1'b0) begin
        if (m_edges < 8) m_cmd = {m_cmd[6:0], t_din};
        m_edges++;
      end
    end else if (prev_clk === 1'b1 && t_clk === 1'b0 && t_cs_n === 1'b0) begin
      t_do = dout_bit(m_edges, m_cmd, mx, my);
    end
    prev_clk = t_clk;
    prev_cs = t_cs_n;
  end
  always @(posedge clk) if (sample_valid === 1'b1) strobes++;
  always @(posedge pen_down) pen_rises++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_strobe(input string tag, input int budget);
    for (int i = 0; i < budget && sample_valid !== 1'b1; i++) @(negedge clk);
    check(tag, sample_valid, 1);
  endtask
  task automatic wait_cs(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && cs_falls < target; i++) @(negedge clk);
    check(tag, cs_falls >= target, 1);
  endtask
  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge clk);
    check(tag, busy, 0);
  endtask
  task automatic wait_pen(input string tag, input logic v, input int budget);
    for (int i = 0; i < budget && pen_down !== v; i++) @(negedge clk);
    check(tag, pen_down, v);
  endtask
  function automatic logic [31:0] qc(int i);
    return (cmd_q.size() > i) ? 32'(cmd_q[i]) : 32'hFFFF;
  endfunction
  function automatic logic [31:0] qe(int i);
    return (edge_q.size() > i) ? 32'(edge_q[i]) : 32'hFFFF;
  endfunction
  task automatic check_pair(input string tag);
    check({tag, "_frames"}, cmd_q.size(), 2);
    check({tag, "_cmd_x"}, qc(0), 32'hD1);
    check({tag, "_cmd_y"}, qc(1), 32'h90);
    check({tag, "_edges_x"}, qe(0), 24);
    check({tag, "_edges_y"}, qe(1), 24);
  endtask
  int s0, c0, c1, p0, r0;
  logic [11:0] vx[4];
  logic [11:0] vy[4];
  initial begin
    enable = 1'b1;
    tick(3);
    check("rst_cs_n", t_cs_n, 1);
    check("rst_t_clk", t_clk, 0);
    check("rst_t_din", t_din, 0);
    check("rst_x", sample_x, 0);
    check("rst_y", sample_y, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_pen", pen_down, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    t_irq_n = 1'b0;
    for (int i = 0; i < 1000 && clk_rises < 30; i++) @(negedge clk);
    check("t1_active", clk_rises >= 30, 1);
    rst = 1'b1;
    #1;
    check("t1_cs_n", t_cs_n, 1);
    check("t1_t_clk", t_clk, 0);
    check("t1_t_din", t_din, 0);
    check("t1_busy", busy, 0);
    check("t1_pen", pen_down, 0);
    check("t1_valid", sample_valid, 0);
    tick(2);
    rst = 1'b0;
    r0 = clk_rises;
    s0 = strobes;
    tick(10);
    check("t1_quiet", clk_rises, r0);
    check("t1_no_strobe", strobes, s0);
    cmd_q.delete();
    edge_q.delete();
    mx = 12'hABC;
    my = 12'h123;
    wait_strobe("t2_strobe", 800);
    check("t2_x", sample_x, 12'hABC);
    check("t2_y", sample_y, 12'h123);
    tick(1);
    check("t2_pulse", sample_valid, 0);
    check("t2_count", strobes - s0, 1);
    check_pair("t2");
    t_irq_n = 1'b1;
    wait_pen("t3_release", 1'b0, 1000);
    wait_idle("t3_idle", 400);
    c0 = cs_falls;
    p0 = pen_rises;
    t_irq_n = 1'b0;
    tick(5);
    t_irq_n = 1'b1;
    tick(450);
    check("t3_pen", pen_down, 0);
    check("t3_cs", cs_falls, c0);
    check("t3_pen_rises", pen_rises, p0);
    mx = 12'($urandom);
    my = 12'($urandom);
    s0 = strobes;
    c0 = cs_falls;
    t_irq_n = 1'b0;
    wait_cs("t4_cs_y", c0 + 2, 1000);
    tick(20);
    t_irq_n = 1'b1;
    wait_idle("t4_idle", 400);
    check("t4_pen_frozen", pen_down, 1);
    check("t4_cs_n", t_cs_n, 1);
    tick(10);
    check("t4_pen", pen_down, 0);
    check("t4_no_strobe", strobes, s0);
    mx = 12'($urandom);
    my = 12'($urandom);
    cmd_q.delete();
    edge_q.delete();
    s0 = strobes;
    c0 = cs_falls;
    t_irq_n = 1'b0;
    wait_cs("t5_cs_x", c0 + 1, 1000);
    tick(10);
    enable = 1'b0;
    wait_idle("t5_idle", 400);
    tick(1);
    check("t5_count", strobes - s0, 1);
    check("t5_x", sample_x, mx);
    check("t5_y", sample_y, my);
    check("t5_cs_n", t_cs_n, 1);
    check_pair("t5");
    c1 = cs_falls;
    tick(3 * SAMPLE_PERIOD);
    check("t5_no_frames", cs_falls, c1);
    vx[0] = 12'h000;
    vy[0] = 12'hFFF;
    vx[1] = 12'hFFF;
    vy[1] = 12'h000;
    for (int i = 2; i < 4; i++) begin
      vx[i] = 12'($urandom);
      vy[i] = 12'($urandom);
    end
    s0 = strobes;
    mx = vx[0];
    my = vy[0];
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_strobe($sformatf("t6_strobe%0d", i), 800);
      check($sformatf("t6_x%0d", i), sample_x, vx[i]);
      check($sformatf("t6_y%0d", i), sample_y, vy[i]);
      tick(1);
      if (i < 3) begin
        mx = vx[i+1];
        my = vy[i+1];
      end
      tick(100);
      check($sformatf("t6_hold_x%0d", i), sample_x, vx[i]);
      check($sformatf("t6_hold_y%0d", i), sample_y, vy[i]);
    end
    check("t6_count", strobes - s0, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
